// File: rtl/piece_rotator.sv
// Piece rotator: rotates a four-cell piece about its pivot, then walks a short
// list of kick offsets, asking an external collision checker about each legal
// candidate until one is free or the list is exhausted.
module piece_rotator #(
  parameter int XSIZE   = 3,
  parameter int YSIZE   = 3,
  parameter int BOARD_W = 8,
  parameter int BOARD_H = 8,
  parameter int NKICK   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  output logic                  ready,
  input  logic                  dir,
  input  logic [3:0][XSIZE:0]   inX,
  input  logic [3:0][YSIZE:0]   inY,
  input  logic [3:0][XSIZE:0]   spinX,
  input  logic [3:0][YSIZE:0]   spinY,
  input  logic [1:0]            spinState,
  output logic                  chk_valid,
  output logic [3:0][XSIZE:0]   chk_x,
  output logic [3:0][YSIZE:0]   chk_y,
  input  logic                  chk_hit,
  output logic                  done,
  output logic                  fail,
  output logic [3:0][XSIZE:0]   outX,
  output logic [3:0][YSIZE:0]   outY,
  output logic [1:0]            newSpin,
  output logic [1:0]            kick_idx
);

  localparam int XW = XSIZE + 1;
  localparam int YW = YSIZE + 1;
  localparam logic [1:0] LAST_KICK = 2'(NKICK - 1);

  typedef enum logic [2:0] {IDLE, CALC, QUERY, WAIT, DONE} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [3:0][XSIZE:0] r_inX;
  logic [3:0][YSIZE:0] r_inY;
  logic [3:0][XSIZE:0] r_spinX;
  logic [3:0][YSIZE:0] r_spinY;
  logic [1:0]          r_spin;
  logic                r_dir;
  logic [3:0][XSIZE:0] r_baseX;
  logic [3:0][YSIZE:0] r_baseY;
  logic [1:0]          r_kick;
  logic                r_success;
  logic                r_done;
  logic                r_fail;
  logic [3:0][XSIZE:0] r_outX;
  logic [3:0][YSIZE:0] r_outY;
  logic [1:0]          r_newSpin;
  logic [1:0]          r_kickIdx;

  logic [1:0]          w_rotSpin;
  logic [1:0]          w_resultSpin;
  logic [3:0][XSIZE:0] w_offX;
  logic [3:0][YSIZE:0] w_offY;
  logic [3:0][XSIZE:0] w_baseX;
  logic [3:0][YSIZE:0] w_baseY;
  logic [XSIZE:0]      w_kdx;
  logic [YSIZE:0]      w_kdy;
  logic [3:0][XSIZE:0] w_candX;
  logic [3:0][YSIZE:0] w_candY;
  logic                w_oob;
  logic                w_lastTry;
  logic                w_attemptFail;

  // Offsets are signed values, so moving one between the X and Y widths sign-extends or truncates.
  function automatic logic [XSIZE:0] toX(input logic [YSIZE:0] v);
    return XW'(signed'(v));
  endfunction

  function automatic logic [YSIZE:0] toY(input logic [XSIZE:0] v);
    return YW'(signed'(v));
  endfunction

  // A counter-clockwise turn undoes the clockwise turn out of the previous spin.
  assign w_rotSpin    = r_dir ? (r_spin - 2'd1) : r_spin;
  assign w_resultSpin = r_dir ? (r_spin - 2'd1) : (r_spin + 2'd1);
  assign w_lastTry    = (r_kick == LAST_KICK);

  assign ready    = (r_state == IDLE);
  assign done     = r_done;
  assign fail     = r_fail;
  assign outX     = r_outX;
  assign outY     = r_outY;
  assign newSpin  = r_newSpin;
  assign kick_idx = r_kickIdx;

  // Rotated offset of each cell for the pivot spin, added to or subtracted from the base position.
  always_comb begin
    w_offX  = '0;
    w_offY  = '0;
    w_baseX = '0;
    w_baseY = '0;
    for (int i = 0; i < 4; i++) begin
      case (w_rotSpin)
        2'd0: begin
          w_offX[i] = r_spinX[i];
          w_offY[i] = r_spinY[i];
        end
        2'd1: begin
          w_offX[i] = -toX(r_spinY[i]);
          w_offY[i] = toY(r_spinX[i]);
        end
        2'd2: begin
          w_offX[i] = -r_spinX[i];
          w_offY[i] = -r_spinY[i];
        end
        default: begin
          w_offX[i] = toX(r_spinY[i]);
          w_offY[i] = -toY(r_spinX[i]);
        end
      endcase
      if (r_dir) begin
        w_baseX[i] = r_inX[i] - w_offX[i];
        w_baseY[i] = r_inY[i] - w_offY[i];
      end else begin
        w_baseX[i] = r_inX[i] + w_offX[i];
        w_baseY[i] = r_inY[i] + w_offY[i];
      end
    end
  end

  // Current kick offset; horizontal kicks mirror for counter-clockwise turns, the drop kick does not.
  always_comb begin
    w_kdx = '0;
    w_kdy = '0;
    case (r_kick)
      2'd1:    w_kdx = r_dir ? '1 : XW'(1);
      2'd2:    w_kdx = r_dir ? XW'(1) : '1;
      2'd3:    w_kdy = '1;
      default: ;
    endcase
  end

  // Candidate cells for the current kick, and whether any of them leaves the board.
  always_comb begin
    w_candX = '0;
    w_candY = '0;
    w_oob   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_candX[i] = r_baseX[i] + w_kdx;
      w_candY[i] = r_baseY[i] + w_kdy;
      if (w_candX[i][XSIZE] || w_candY[i][YSIZE] ||
          (int'(w_candX[i]) >= BOARD_W) || (int'(w_candY[i]) >= BOARD_H)) begin
        w_oob = 1'b1;
      end
    end
  end

  // State register; reset abandons any in-flight rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the collision query strobe; an illegal candidate never reaches the checker.
  always_comb begin
    w_nextState   = r_state;
    w_attemptFail = 1'b0;
    chk_valid     = 1'b0;
    chk_x         = '0;
    chk_y         = '0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_nextState = CALC;
        end
      end
      CALC: begin
        w_nextState = QUERY;
      end
      QUERY: begin
        if (w_oob) begin
          w_attemptFail = 1'b1;
        end else begin
          chk_valid   = 1'b1;
          chk_x       = w_candX;
          chk_y       = w_candY;
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (chk_hit) begin
          w_attemptFail = 1'b1;
        end else begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (w_attemptFail) begin
      w_nextState = w_lastTry ? DONE : QUERY;
    end
  end

  // Datapath: capture the request, hold the base candidate, step kicks, and publish the result from DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inX     <= '0;
      r_inY     <= '0;
      r_spinX   <= '0;
      r_spinY   <= '0;
      r_spin    <= '0;
      r_dir     <= 1'b0;
      r_baseX   <= '0;
      r_baseY   <= '0;
      r_kick    <= '0;
      r_success <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_outX    <= '0;
      r_outY    <= '0;
      r_newSpin <= '0;
      r_kickIdx <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_inX   <= inX;
            r_inY   <= inY;
            r_spinX <= spinX;
            r_spinY <= spinY;
            r_spin  <= spinState;
            r_dir   <= dir;
          end
        end
        CALC: begin
          r_baseX   <= w_baseX;
          r_baseY   <= w_baseY;
          r_kick    <= '0;
          r_success <= 1'b0;
        end
        WAIT: begin
          if (!chk_hit) begin
            r_success <= 1'b1;
          end
        end
        DONE: begin
          r_done    <= 1'b1;
          r_fail    <= !r_success;
          r_kickIdx <= r_kick;
          r_outX    <= r_success ? w_candX : r_inX;
          r_outY    <= r_success ? w_candY : r_inY;
          r_newSpin <= r_success ? w_resultSpin : r_spin;
        end
        default: ;
      endcase
      if (w_attemptFail && !w_lastTry) begin
        r_kick <= r_kick + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_piece_rotator.sv
// Scoreboard bench for piece_rotator: the stimulus side predicts every collision
// query and every final result from a plain-integer model of the rotation and kick
// rules; a monitor answers queries and checks whatever the DUT presents.
module tb_piece_rotator;

  localparam int XS = 3;
  localparam int YS = 3;
  localparam int XW = XS + 1;
  localparam int YW = YS + 1;
  localparam int BW = 8;
  localparam int BH = 8;
  localparam int NK = 4;
  localparam int XVW = 4 * XW;
  localparam int YVW = 4 * YW;

  typedef logic [3:0][XS:0] xvec_t;
  typedef logic [3:0][YS:0] yvec_t;

  typedef struct {
    xvec_t x;
    yvec_t y;
    logic  hit;
  } query_t;

  typedef struct {
    xvec_t      x;
    yvec_t      y;
    logic [1:0] spin;
    logic       fail;
    logic [1:0] kick;
    int         lat;
    int         startCycle;
  } result_t;

  logic       clk;
  logic       reset;
  logic       req;
  logic       ready;
  logic       dir;
  xvec_t      inX;
  yvec_t      inY;
  xvec_t      spinX;
  yvec_t      spinY;
  logic [1:0] spinState;
  logic       chk_valid;
  xvec_t      chk_x;
  yvec_t      chk_y;
  logic       chk_hit;
  logic       done;
  logic       fail;
  xvec_t      outX;
  yvec_t      outY;
  logic [1:0] newSpin;
  logic [1:0] kick_idx;

  query_t  qQ[$];
  result_t rQ[$];
  result_t lastRes;
  int      testsRun;
  int      testsFailed;
  int      cycle;
  int      doneCount;

  piece_rotator #(
    .XSIZE(XS), .YSIZE(YS), .BOARD_W(BW), .BOARD_H(BH), .NKICK(NK)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready), .dir(dir),
    .inX(inX), .inY(inY), .spinX(spinX), .spinY(spinY), .spinState(spinState),
    .chk_valid(chk_valid), .chk_x(chk_x), .chk_y(chk_y), .chk_hit(chk_hit),
    .done(done), .fail(fail), .outX(outX), .outY(outY),
    .newSpin(newSpin), .kick_idx(kick_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic finishRun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    finishRun();
  endtask

  function automatic int sIntX(input logic [XS:0] v);
    return v[XS] ? int'(v) - (1 << XW) : int'(v);
  endfunction

  function automatic int sIntY(input logic [YS:0] v);
    return v[YS] ? int'(v) - (1 << YW) : int'(v);
  endfunction

  function automatic xvec_t mkX(input int a, input int b, input int c, input int d);
    xvec_t v;
    v[0] = XW'(a); v[1] = XW'(b); v[2] = XW'(c); v[3] = XW'(d);
    return v;
  endfunction

  function automatic yvec_t mkY(input int a, input int b, input int c, input int d);
    yvec_t v;
    v[0] = YW'(a); v[1] = YW'(b); v[2] = YW'(c); v[3] = YW'(d);
    return v;
  endfunction

  // Spin n is the unrotated offset turned a quarter (x,y)->(-y,x) n times.
  task automatic spinOffset(input int sx, input int sy, input int n, output int bx, output int by);
    int t;
    bx = sx;
    by = sy;
    for (int j = 0; j < n; j++) begin
      t  = bx;
      bx = -by;
      by = t;
    end
  endtask

  // Reference model: pushes each expected collision query and returns the final result.
  task automatic runModel(input xvec_t ix, input yvec_t iy, input xvec_t sx, input yvec_t sy,
                          input logic [1:0] s, input logic d, input logic [3:0] hits,
                          output result_t r);
    int kdx[4] = '{0, 1, -1, 0};
    int kdy[4] = '{0, 0, 0, -1};
    int baseX[4];
    int baseY[4];
    int bx, by, cx, cy, pivot;
    bit oob, success;
    query_t q;
    pivot = d ? (int'(s) + 3) % 4 : int'(s);
    for (int i = 0; i < 4; i++) begin
      spinOffset(sIntX(sx[i]), sIntY(sy[i]), pivot, bx, by);
      baseX[i] = d ? int'(ix[i]) - bx : int'(ix[i]) + bx;
      baseY[i] = d ? int'(iy[i]) - by : int'(iy[i]) + by;
    end
    r.x = ix; r.y = iy; r.spin = s; r.fail = 1'b1; r.kick = 2'(NK - 1);
    r.lat = 2; r.startCycle = 0;
    success = 0;
    for (int k = 0; k < NK && !success; k++) begin
      oob = 0;
      for (int i = 0; i < 4; i++) begin
        cx = (baseX[i] + (d ? -kdx[k] : kdx[k])) & ((1 << XW) - 1);
        cy = (baseY[i] + kdy[k]) & ((1 << YW) - 1);
        q.x[i] = XW'(cx);
        q.y[i] = YW'(cy);
        if (cx >= BW || cx >= (1 << XS) || cy >= BH || cy >= (1 << YS)) oob = 1;
      end
      if (oob) begin
        r.lat += 1;
      end else begin
        r.lat += 2;
        q.hit = hits[k];
        qQ.push_back(q);
        if (!hits[k]) begin
          success = 1;
          r.x = q.x; r.y = q.y;
          r.spin = d ? 2'((int'(s) + 3) % 4) : 2'((int'(s) + 1) % 4);
          r.fail = 1'b0;
          r.kick = 2'(k);
        end
      end
    end
    r.lat += 1;
  endtask

  // One request: predict, drive, poke ignored garbage while busy, then wait for completion (or abort in WAIT).
  task automatic applyStimulus(input xvec_t ix, input yvec_t iy, input xvec_t sx, input yvec_t sy,
                               input logic [1:0] s, input logic d, input logic [3:0] hits,
                               input bit abortInWait);
    result_t r;
    int n;
    int target;
    checkOutput("heldResult", {outX, outY, newSpin, fail, kick_idx},
                {lastRes.x, lastRes.y, lastRes.spin, lastRes.fail, lastRes.kick});
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) timeoutFail("readyWait");
    inX = ix; inY = iy; spinX = sx; spinY = sy; spinState = s; dir = d; req = 1'b1;
    runModel(ix, iy, sx, sy, s, d, hits, r);
    r.startCycle = cycle;
    target = doneCount + 1;
    if (!abortInWait) rQ.push_back(r);
    @(negedge clk);
    inX = XVW'($urandom); inY = YVW'($urandom); spinX = XVW'($urandom); spinY = YVW'($urandom);
    spinState = 2'($urandom); dir = 1'($urandom);
    @(negedge clk);
    req = 1'b0;
    if (abortInWait) begin
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("readyAfterReset", ready, 1);
      checkOutput("clearedAfterReset", {outX, outY, newSpin, fail, kick_idx, done}, 0);
      lastRes.x = '0; lastRes.y = '0; lastRes.spin = '0; lastRes.fail = 1'b0; lastRes.kick = '0;
      repeat (8) @(negedge clk);
      checkOutput("noDoneAfterReset", doneCount, target - 1);
    end else begin
      n = 0;
      while (doneCount < target && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (doneCount < target) timeoutFail("doneWait");
      @(negedge clk);
    end
  endtask

  // Monitor and collision responder: answers each query, then scrambles chk_hit outside WAIT.
  initial begin : monitor
    bit hold;
    query_t q;
    result_t r;
    hold = 0;
    forever begin
      @(negedge clk);
      if (chk_valid === 1'b1) begin
        if (qQ.size() == 0) begin
          checkOutput("unexpectedQuery", chk_valid, 0);
          chk_hit = 1'b0;
        end else begin
          q = qQ.pop_front();
          checkOutput("queryCells", {chk_x, chk_y}, {q.x, q.y});
          chk_hit = q.hit;
        end
        hold = 1;
      end else if (hold) begin
        hold = 0;
      end else begin
        chk_hit = 1'($urandom_range(0, 1));
      end
      if (done === 1'b1) begin
        if (rQ.size() == 0) begin
          checkOutput("unexpectedDone", done, 0);
        end else begin
          r = rQ.pop_front();
          checkOutput("outXY", {outX, outY}, {r.x, r.y});
          checkOutput("newSpin", newSpin, r.spin);
          checkOutput("failFlag", fail, r.fail);
          checkOutput("kickIdx", kick_idx, r.kick);
          checkOutput("latency", cycle - r.startCycle, r.lat);
          checkOutput("allQueriesSeen", qQ.size(), 0);
          lastRes = r;
        end
        doneCount++;
      end
    end
  end

  initial begin : watchdog
    #300000;
    timeoutFail("globalWatchdog");
  end

  initial begin : stimulus
    xvec_t ix, sx;
    yvec_t iy, sy;
    testsRun = 0; testsFailed = 0; cycle = 0; doneCount = 0;
    lastRes.x = '0; lastRes.y = '0; lastRes.spin = '0; lastRes.fail = 1'b0; lastRes.kick = '0;
    lastRes.lat = 0; lastRes.startCycle = 0;
    reset = 1'b1; req = 1'b0; dir = 1'b0; chk_hit = 1'b0;
    inX = '0; inY = '0; spinX = '0; spinY = '0; spinState = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetReady", ready, 1);
    checkOutput("resetStrobes", {done, chk_valid, fail}, 0);
    checkOutput("resetResult", {outX, outY, newSpin, kick_idx}, 0);
    checkOutput("resetQuery", {chk_x, chk_y}, 0);
    req = 1'b1;
    @(negedge clk);
    checkOutput("reqDuringReset", ready, 1);
    reset = 1'b0;
    req = 1'b0;
    @(negedge clk);

    $display("[TB] directed: clean rotate");
    applyStimulus(mkX(3,3,3,3), mkY(3,3,3,3), mkX(0,1,2,1), mkY(0,0,0,1), 2'd1, 1'b0, 4'b0000, 0);
    $display("[TB] directed: kick after first hit");
    applyStimulus(mkX(3,3,3,3), mkY(3,3,3,3), mkX(0,1,2,1), mkY(0,0,0,1), 2'd1, 1'b0, 4'b0001, 0);
    $display("[TB] directed: out-of-bounds skip");
    applyStimulus(mkX(0,0,0,0), mkY(3,3,3,3), mkX(0,0,0,0), mkY(1,1,1,1), 2'd1, 1'b0, 4'b0000, 0);
    $display("[TB] directed: every kick collides");
    applyStimulus(mkX(3,3,3,3), mkY(3,3,3,3), mkX(0,1,2,1), mkY(0,0,0,1), 2'd1, 1'b0, 4'b1111, 0);
    $display("[TB] directed: counter-clockwise inverse");
    applyStimulus(mkX(3,3,3,2), mkY(3,4,5,4), mkX(0,1,2,1), mkY(0,0,0,1), 2'd2, 1'b1, 4'b0000, 0);
    $display("[TB] directed: counter-clockwise mirrored kicks");
    applyStimulus(mkX(4,4,4,4), mkY(4,4,4,4), mkX(0,1,2,1), mkY(0,0,0,1), 2'd0, 1'b1, 4'b0011, 0);
    $display("[TB] directed: spin wrap 3 -> 0");
    applyStimulus(mkX(4,4,4,4), mkY(2,2,2,2), mkX(0,1,-1,0), mkY(0,0,0,1), 2'd3, 1'b0, 4'b0000, 0);
    $display("[TB] directed: reset while waiting on the checker");
    applyStimulus(mkX(3,3,3,3), mkY(3,3,3,3), mkX(0,1,2,1), mkY(0,0,0,1), 2'd1, 1'b0, 4'b0000, 1);
    applyStimulus(mkX(3,3,3,3), mkY(3,3,3,3), mkX(0,1,2,1), mkY(0,0,0,1), 2'd1, 1'b0, 4'b0000, 0);

    $display("[TB] randomized requests");
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 4; i++) begin
        ix[i] = ($urandom_range(0, 9) == 0) ? XW'($urandom_range(0, 15)) : XW'($urandom_range(0, 7));
        iy[i] = ($urandom_range(0, 9) == 0) ? YW'($urandom_range(0, 15)) : YW'($urandom_range(0, 7));
        sx[i] = XW'($urandom_range(0, 4) - 2);
        sy[i] = YW'($urandom_range(0, 4) - 2);
      end
      applyStimulus(ix, iy, sx, sy, 2'($urandom), 1'($urandom), 4'($urandom), 0);
    end

    checkOutput("scoreboardEmpty", rQ.size() + qQ.size(), 0);
    finishRun();
  end

endmodule

// File: doc/piece_rotator.md
PIECE_ROTATOR -- requirements
Module: piece_rotator

Interface
REQ-001 SHALL have parameter XSIZE, default 3, X coordinate magnitude width; coordinate ports carry XSIZE+1 bits, MSB is the negative flag.
REQ-002 SHALL have parameter YSIZE, default 3, Y coordinate magnitude width; coordinate ports carry YSIZE+1 bits, MSB is the negative flag.
REQ-003 SHALL have parameter BOARD_W, default 8, board columns; legal X is 0..BOARD_W-1.
REQ-004 SHALL have parameter BOARD_H, default 8, board rows; legal Y is 0..BOARD_H-1.
REQ-005 SHALL have parameter NKICK, default 4, range 1..4, number of kick offsets tried per request.
REQ-006 Ports, one per line: name, direction, width, meaning. Clock and reset come first:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  rotation request.
- ready  out  1  high in IDLE only.
- dir  in  1  rotation direction: 0 = clockwise, 1 = counter-clockwise.
- inX / inY  in  4x(XSIZE+1) / 4x(YSIZE+1)  current pivot-base coordinates of the 4 cells.
- spinX / spinY  in  same widths  unrotated cell offsets.
- spinState  in  2  current spin.
- chk_valid  out  1  collision query strobe.
- chk_x / chk_y  out  same widths as inX / inY  candidate cells for the collision query.
- chk_hit  in  1  collision result, valid exactly one cycle after chk_valid.
- done  out  1  one-cycle completion pulse.
- fail  out  1  high when no candidate was legal.
- outX / outY  out  same widths as inX / inY  result coordinates.
- newSpin  out  2  resulting spin.
- kick_idx  out  2  index of the kick that succeeded.

Function
REQ-007 SHALL capture inX, inY, spinX, spinY, spinState and dir on the cycle where req and ready are both high; inputs are ignored at all other times.
REQ-008 Rotation table SHALL give offset b per cell for spin s: s=0 b=(sx,sy); s=1 b=(-sy,sx); s=2 b=(-sx,-sy); s=3 b=(sy,-sx). Negation is two's complement at XSIZE+1 / YSIZE+1 bits.
REQ-009 For dir=0, candidate base SHALL be in+b[spinState], and the result spin SHALL be spinState+1 mod 4.
REQ-010 For dir=1, candidate base SHALL be in-b[spinState-1 mod 4], and the result spin SHALL be spinState-1 mod 4.
REQ-011 Kick offsets (dx,dy) in try order SHALL be k0=(0,0), k1=(+1,0), k2=(-1,0), k3=(0,-1); dx is negated when dir=1; only k0..k(NKICK-1) are tried.
REQ-012 Sums SHALL be truncated to XSIZE+1 / YSIZE+1 bits; there is no saturation.
REQ-013 A candidate SHALL be out-of-bounds (OOB) when any cell has MSB set, X >= BOARD_W, or Y >= BOARD_H.
REQ-014 FSM states: IDLE, CALC, QUERY, WAIT, DONE.
REQ-015 FSM transitions:
- IDLE goes to CALC on accept.
- CALC registers the base candidate for 1 cycle, sets kick index 0, then goes to QUERY.
REQ-016 In QUERY, an OOB candidate SHALL skip the query: no chk_valid, the attempt counts as failed, 1 cycle.
REQ-017 In QUERY, a legal candidate SHALL assert chk_valid for exactly 1 cycle with chk_x/chk_y equal to the candidate, then go to WAIT.
REQ-018 WAIT SHALL sample chk_hit: hit=0 means success and goes to DONE; hit=1 is a failed attempt.
REQ-019 A failed attempt SHALL advance the kick index and return to QUERY if kicks remain; otherwise it SHALL go to DONE with fail=1.
REQ-020 DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-021 On success: outX/outY = accepted candidate, newSpin = result spin, fail=0, kick_idx = winning index.
REQ-022 On fail: outX/outY = captured inX/inY, newSpin = captured spinState, fail=1, kick_idx = NKICK-1.
REQ-023 outX, outY, newSpin, fail and kick_idx SHALL hold their values from DONE until the next DONE.
REQ-024 req while not ready SHALL be ignored; it is not queued.
REQ-025 Latency, accept to done: 2 + sum over tried kicks (2 if queried, 1 if OOB) + 1 cycles; best case 5.
REQ-026 chk_hit outside WAIT SHALL be ignored.

Reset
REQ-027 reset SHALL have priority over all other inputs.
REQ-028 reset SHALL force state IDLE on the next edge, including mid-operation; the in-flight request is dropped with no done.
REQ-029 Reset values: ready=1 after reset; done=0, chk_valid=0, fail=0, outX=0, outY=0, chk_x=0, chk_y=0, newSpin=0, kick_idx=0.

Verification
REQ-030 Clean rotate: inX=inY={3,3,3,3}, spinX={0,1,2,1}, spinY={0,0,0,1}, spinState=1, dir=0, chk_hit=0 -> outX={3,3,3,2}, outY={3,4,5,4}, newSpin=2, fail=0, kick_idx=0, done 5 cycles after accept.
REQ-031 Kick: same stimulus as REQ-030, chk_hit=1 on the first query then 0 -> second chk_x={4,4,4,3}, kick_idx=1, done 7 cycles after accept.
REQ-032 OOB skip: inX={0,0,0,0}, spinState=1, spinY={1,1,1,1}, dir=0, NKICK=2, chk_hit=0 -> k0 is OOB with no chk_valid, k1 legal, success with kick_idx=1.
REQ-033 All fail: chk_hit held at 1, NKICK=4 -> exactly 4 chk_valid pulses, fail=1, outX/outY = inputs, newSpin = spinState.
REQ-034 CCW inverse: a CW result fed back with dir=1 and spinState=2 -> returns the original coordinates and newSpin=1.
REQ-035 Reset mid-op: reset asserted in WAIT -> no done, ready=1 next cycle, a new req is accepted and completes normally.
